// File: rtl/bus_control_pkg.sv
// bus_control_pkg: op and FSM state encodings for the external memory bus controller
package bus_control_pkg;
  typedef enum logic [1:0] {
    OP_NONE   = 2'b00,
    OP_ROM_RD = 2'b01,
    OP_RAM_RD = 2'b10,
    OP_RAM_WR = 2'b11
  } op_e;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_LATCH  = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4
  } state_e;
endpackage

// File: rtl/bus_control_wait_cnt.sv
// bus_control_wait_cnt: loadable down-counter that stretches the strobe by the requested wait states
module bus_control_wait_cnt #(
  parameter int WAIT_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_b_i,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [WAIT_W-1:0] din_i,
  output logic              zero_o
);
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? din_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk_i or negedge rst_b_i)
    if (!rst_b_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/bus_control_seq.sv
// bus_control_seq: timed external memory bus cycles with ALE, wait states and idle port pass-through
module bus_control_seq
  import bus_control_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int WAIT_W   = 3,
  parameter int MUX_MODE = 1
) (
  input  logic                     bus_control_clk_i,
  input  logic                     bus_control_rst_b_i,
  input  logic                     bus_control_req_i,
  input  logic [1:0]               bus_control_op_i,
  input  logic [ADDR_W-1:0]        bus_control_addr_i,
  input  logic [DATA_W-1:0]        bus_control_wdata_i,
  input  logic [WAIT_W-1:0]        bus_control_wait_i,
  output logic                     bus_control_ack_o,
  output logic                     bus_control_busy_o,
  output logic [DATA_W-1:0]        bus_control_rdata_o,
  input  logic                     bus_control_ea_b_i,
  output logic                     bus_control_core_ea_b_o,
  input  logic [DATA_W-1:0]        bus_control_core_p0_i,
  input  logic [DATA_W-1:0]        bus_control_core_p0en_i,
  input  logic [ADDR_W-DATA_W-1:0] bus_control_core_p2_i,
  input  logic [ADDR_W-DATA_W-1:0] bus_control_core_p2en_i,
  input  logic [DATA_W-1:0]        bus_control_core_p4_i,
  input  logic                     bus_control_core_p3_6_i,
  input  logic                     bus_control_core_p3_7_i,
  input  logic                     bus_control_core_p3en_6_i,
  input  logic                     bus_control_core_p3en_7_i,
  input  logic [DATA_W-1:0]        bus_control_ports_p0_i,
  output logic [DATA_W-1:0]        bus_control_core_p0_o,
  output logic [DATA_W-1:0]        bus_control_core_p0en_o,
  output logic [DATA_W-1:0]        bus_control_core_p4_o,
  output logic [ADDR_W-DATA_W-1:0] bus_control_core_p2_o,
  output logic [ADDR_W-DATA_W-1:0] bus_control_core_p2en_o,
  output logic                     bus_control_core_p3_6_o,
  output logic                     bus_control_core_p3_7_o,
  output logic                     bus_control_core_p3en_6_o,
  output logic                     bus_control_core_p3en_7_o,
  output logic                     bus_control_ale_o,
  output logic                     bus_control_psen_b_o
);
  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              accept, cnt_zero, active, strobe, addr_ph, wr_ph, wr_b, rd_b;
  bus_control_wait_cnt #(.WAIT_W(WAIT_W)) u_wait_cnt (
    .clk_i  (bus_control_clk_i),
    .rst_b_i(bus_control_rst_b_i),
    .load_i (accept),
    .en_i   (strobe),
    .din_i  (bus_control_wait_i),
    .zero_o (cnt_zero)
  );
  always_comb begin
    accept  = bus_control_req_i && bus_control_op_i != OP_NONE && (state_q == S_IDLE || state_q == S_HOLD);
    strobe  = state_q == S_STROBE;
    state_d = accept ? S_ADDR :
              state_q == S_ADDR   ? (MUX_MODE != 0 ? S_LATCH : S_STROBE) :
              state_q == S_LATCH  ? S_STROBE :
              state_q == S_STROBE ? (cnt_zero ? S_HOLD : S_STROBE) : S_IDLE;
    op_d    = accept ? bus_control_op_i : op_q;
    addr_d  = accept ? bus_control_addr_i : addr_q;
    wdata_d = accept ? bus_control_wdata_i : wdata_q;
    // read data lands on the last strobe edge; writes leave it untouched
    rdata_d = (strobe && cnt_zero && op_q != OP_RAM_WR) ? bus_control_ports_p0_i : rdata_q;
  end
  always_ff @(posedge bus_control_clk_i or negedge bus_control_rst_b_i)
    if (!bus_control_rst_b_i) begin
      state_q <= S_IDLE;
      op_q    <= OP_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  always_comb begin
    active  = state_q != S_IDLE;
    addr_ph = MUX_MODE != 0 && (state_q == S_ADDR || state_q == S_LATCH);
    wr_ph   = op_q == OP_RAM_WR && (strobe || state_q == S_HOLD);
    wr_b    = !(strobe && op_q == OP_RAM_WR);
    rd_b    = !(strobe && op_q == OP_RAM_RD);
  end
  assign bus_control_ack_o         = state_q == S_HOLD;
  assign bus_control_busy_o        = active;
  assign bus_control_rdata_o       = rdata_q;
  assign bus_control_core_ea_b_o   = bus_control_ea_b_i;
  assign bus_control_ale_o         = MUX_MODE != 0 && state_q == S_ADDR;
  assign bus_control_psen_b_o      = !(strobe && op_q == OP_ROM_RD);
  assign bus_control_core_p0_o     = !active ? bus_control_core_p0_i : addr_ph ? addr_q[DATA_W-1:0] :
                                     wr_ph ? wdata_q : '0;
  assign bus_control_core_p0en_o   = !active ? bus_control_core_p0en_i : (addr_ph || wr_ph) ? '1 : '0;
  assign bus_control_core_p2_o     = active ? addr_q[ADDR_W-1:DATA_W] : bus_control_core_p2_i;
  assign bus_control_core_p2en_o   = active ? '1 : bus_control_core_p2en_i;
  assign bus_control_core_p4_o     = active ? addr_q[DATA_W-1:0] : bus_control_core_p4_i;
  assign bus_control_core_p3_6_o   = active ? wr_b : bus_control_core_p3_6_i;
  assign bus_control_core_p3_7_o   = active ? rd_b : bus_control_core_p3_7_i;
  assign bus_control_core_p3en_6_o = active ? 1'b1 : bus_control_core_p3en_6_i;
  assign bus_control_core_p3en_7_o = active ? 1'b1 : bus_control_core_p3en_7_i;
endmodule

// File: tb/tb_bus_control_seq.sv
// tb_bus_control_seq: scoreboard bench driving a multiplexed and a demultiplexed controller side by side
`timescale 1ns/1ps
module tb_bus_control_seq;
  import bus_control_pkg::*;
  typedef struct {int cyc; logic [7:0] rd;} exp_t;
  logic clk = 1'b0, rst_b = 1'b0;
  logic [1:0] req = '0, op_i = '0;
  logic [15:0] addr_i = '0;
  logic [7:0] wdata_i = '0, ports_p0 = '0;
  logic [2:0] wait_i = '0;
  logic ea_b_i = 1'b1;
  logic [7:0] core_p0 = 8'h77, core_p0en = 8'h0F, core_p2 = 8'hA5, core_p2en = 8'h3C, core_p4 = 8'h99;
  logic core_p36 = 1'b1, core_p37 = 1'b1, core_p3en6 = 1'b0, core_p3en7 = 1'b0;
  logic [1:0] ack, busy, ea_o, p36, p37, p3en6, p3en7, ale, psen;
  logic [7:0] rdata [2], p0_o [2], p0en_o [2], p4_o [2], p2_o [2], p2en_o [2];
  int cyc = 0, tests = 0, fails = 0;
  exp_t q0[$], q1[$];
  logic rd_a [16], ale_a [16], ack_a [16];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    bus_control_seq #(.ADDR_W(16), .DATA_W(8), .WAIT_W(3), .MUX_MODE(g)) u_dut (
      .bus_control_clk_i(clk), .bus_control_rst_b_i(rst_b), .bus_control_req_i(req[g]),
      .bus_control_op_i(op_i), .bus_control_addr_i(addr_i), .bus_control_wdata_i(wdata_i),
      .bus_control_wait_i(wait_i), .bus_control_ack_o(ack[g]), .bus_control_busy_o(busy[g]),
      .bus_control_rdata_o(rdata[g]), .bus_control_ea_b_i(ea_b_i), .bus_control_core_ea_b_o(ea_o[g]),
      .bus_control_core_p0_i(core_p0), .bus_control_core_p0en_i(core_p0en), .bus_control_core_p2_i(core_p2),
      .bus_control_core_p2en_i(core_p2en), .bus_control_core_p4_i(core_p4),
      .bus_control_core_p3_6_i(core_p36), .bus_control_core_p3_7_i(core_p37),
      .bus_control_core_p3en_6_i(core_p3en6), .bus_control_core_p3en_7_i(core_p3en7),
      .bus_control_ports_p0_i(ports_p0), .bus_control_core_p0_o(p0_o[g]), .bus_control_core_p0en_o(p0en_o[g]),
      .bus_control_core_p4_o(p4_o[g]), .bus_control_core_p2_o(p2_o[g]), .bus_control_core_p2en_o(p2en_o[g]),
      .bus_control_core_p3_6_o(p36[g]), .bus_control_core_p3_7_o(p37[g]),
      .bus_control_core_p3en_6_o(p3en6[g]), .bus_control_core_p3en_7_o(p3en7[g]),
      .bus_control_ale_o(ale[g]), .bus_control_psen_b_o(psen[g])
    );
  end
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic strobe_of(input int m, input logic [1:0] op);
    return op == OP_ROM_RD ? psen[m] : op == OP_RAM_RD ? p37[m] : p36[m];
  endfunction
  always @(negedge clk)
    for (int m = 0; m < 2; m++)
      if (ack[m] === 1'b1) begin
        exp_t e;
        if ((m == 1 ? q1.size() : q0.size()) == 0) chk($sformatf("unexpected_ack_dut%0d", m), 1, 0);
        else begin
          if (m == 1) e = q1.pop_front();
          else e = q0.pop_front();
          chk($sformatf("ack_cycle_dut%0d", m), cyc + 1, e.cyc);
          chk($sformatf("rdata_dut%0d", m), rdata[m], e.rd);
        end
      end
  task automatic issue(input int m, input logic [1:0] op, input logic [15:0] a, input logic [7:0] wd,
                       input logic [2:0] w, input logic [7:0] er, input bit expect_ack);
    exp_t e;
    op_i = op; addr_i = a; wdata_i = wd; wait_i = w; req[m] = 1'b1;
    e.cyc = cyc + 1 + (m == 1 ? 4 : 3) + int'(w);
    e.rd = er;
    if (expect_ack) begin
      if (m == 1) q1.push_back(e);
      else q0.push_back(e);
    end
    @(negedge clk);
    req[m] = 1'b0; op_i = OP_NONE; addr_i = '0; wdata_i = '0; wait_i = '0;
  endtask
  task automatic watch(input int m, input int n, input logic [1:0] op, input logic [7:0] wd,
                       output int lo, output int al, output int pe);
    lo = 0; al = 0; pe = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (!strobe_of(m, op)) begin
        lo++;
        if (op == OP_RAM_WR ? (p0_o[m] == wd && p0en_o[m] == 8'hFF) : p0en_o[m] == 8'h00) pe++;
      end
      al += int'(ale[m]);
    end
  endtask
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int lo, al, pe, a1, al2, cnt;
    ea_b_i = 1'b0;
    repeat (2) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rst_p2_dut%0d", m), p2_o[m], 8'hA5);
      chk($sformatf("rst_p0_dut%0d", m), p0_o[m], 8'h77);
      chk($sformatf("rst_psen_dut%0d", m), psen[m], 1);
      chk($sformatf("rst_ale_dut%0d", m), ale[m], 0);
      chk($sformatf("rst_busy_dut%0d", m), busy[m], 0);
      chk($sformatf("rst_ack_dut%0d", m), ack[m], 0);
      chk($sformatf("rst_rdata_dut%0d", m), rdata[m], 0);
      chk($sformatf("rst_p3en6_dut%0d", m), p3en6[m], 0);
      chk($sformatf("rst_ea_dut%0d", m), ea_o[m], 0);
    end
    rst_b = 1'b1; ea_b_i = 1'b1;
    @(negedge clk);
    chk("ea_pass", ea_o[1], 1);
    ports_p0 = 8'h5A;
    issue(1, OP_ROM_RD, 16'h1234, 8'h00, 3'd0, 8'h5A, 1'b1);
    chk("rom_ale", ale[1], 1);
    chk("rom_p0_addr", p0_o[1], 8'h34);
    chk("rom_p2", p2_o[1], 8'h12);
    chk("rom_p0en", p0en_o[1], 8'hFF);
    watch(1, 5, OP_ROM_RD, 8'h00, lo, al, pe);
    chk("rom_psen_cycles", lo, 1);
    chk("rom_ale_cycles", al, 1);
    chk("rom_p0en_read", pe, 1);
    ports_p0 = 8'hEE;
    issue(1, OP_RAM_WR, 16'h00F0, 8'hC3, 3'd3, 8'h5A, 1'b1);
    chk("wr_p0_addr", p0_o[1], 8'hF0);
    chk("wr_p2", p2_o[1], 8'h00);
    watch(1, 8, OP_RAM_WR, 8'hC3, lo, al, pe);
    chk("wr_strobe_cycles", lo, 4);
    chk("wr_data_driven", pe, 4);
    chk("wr_ale_cycles", al, 1);
    ports_p0 = 8'h11; op_i = OP_RAM_RD; addr_i = 16'h2000; wait_i = 3'd1; req[1] = 1'b1;
    q1.push_back('{cyc + 6, 8'h11});
    @(negedge clk);
    addr_i = 16'h2001;
    q1.push_back('{cyc + 10, 8'h22});
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      rd_a[i] = p37[1]; ale_a[i] = ale[1]; ack_a[i] = ack[1];
      if (i == 1) chk("b2b_held_addr", {p2_o[1], p4_o[1]}, 16'h2000);
      if (i == 4) ports_p0 = 8'h22;
      if (i == 5) begin
        chk("b2b_addr2", {p2_o[1], p0_o[1]}, 16'h2001);
        req[1] = 1'b0; op_i = OP_NONE; addr_i = '0; wait_i = '0;
      end
    end
    a1 = -1; al2 = -1; cnt = 0; lo = 0; al = 0;
    for (int i = 0; i < 11; i++) begin
      if (ack_a[i] && a1 < 0) a1 = i;
      if (ale_a[i]) begin
        cnt++;
        if (cnt == 2) al2 = i;
      end
      if (!rd_a[i]) lo++;
    end
    chk("b2b_rd_cycles", lo, 4);
    chk("b2b_ale_count", cnt, 2);
    chk("b2b_ale_after_ack", al2 - a1, 1);
    chk("b2b_rd_high_hold", a1 >= 0 ? int'(rd_a[a1]) : 0, 1);
    ports_p0 = 8'h9E;
    issue(0, OP_RAM_RD, 16'h4321, 8'h00, 3'd7, 8'h9E, 1'b1);
    chk("dmx_p2", p2_o[0], 8'h43);
    chk("dmx_p4", p4_o[0], 8'h21);
    watch(0, 11, OP_RAM_RD, 8'h00, lo, al, pe);
    chk("dmx_rd_cycles", lo, 8);
    chk("dmx_ale_cycles", al, 0);
    chk("dmx_p0en_read", pe, 8);
    op_i = OP_NONE; req[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("nop_busy", busy[1], 0);
    end
    req[1] = 1'b0;
    issue(1, OP_RAM_RD, 16'h5555, 8'h00, 3'd5, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_mid_rd_active", p37[1], 0);
    #2 rst_b = 1'b0;
    #1;
    chk("rst_mid_rd_high", p37[1], 1);
    chk("rst_mid_psen", psen[1], 1);
    chk("rst_mid_busy", busy[1], 0);
    chk("rst_mid_p2_pass", p2_o[1], 8'hA5);
    chk("rst_mid_p3en7_pass", p3en7[1], 0);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (12) @(negedge clk);
    chk("rst_mid_idle", busy[1], 0);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
